// File: rtl/sum_accumulator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sum_accumulator
//
// Accumulates 9-bit beats ({in_cout, in_sum} from an upstream 8-bit adder)
// into a saturating ACC_W-bit total. A frame closes after COUNT accepted
// beats, or early on flush once at least one beat is in. The closed frame is
// held on the output until the downstream side takes it.
//
// Parameters
//   COUNT  beats per frame (1..255)
//   ACC_W  accumulator/result width (9..32)
//
// Ports
//   clk        clock, all state changes on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   block can accept a beat this cycle (state-only)
//   in_sum     upstream adder sum, 8 bits
//   in_cout    upstream adder carry-out
//   flush      close the current frame early
//   out_valid  frame result valid
//   out_ready  downstream accepts the result
//   out_acc    frame total (saturated)
//   out_cnt    beats in the frame
//   out_sat    frame total saturated
// -----------------------------------------------------------------------------
module sum_accumulator #(
    parameter int COUNT = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_sum,
    input  logic             in_cout,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       out_cnt,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] COUNT_L = 8'(COUNT);

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [7:0]       cnt, cnt_next;
    logic             sat, sat_next;
    logic             started;

    logic             accept;
    logic [ACC_W:0]   beat_ext;
    logic [ACC_W:0]   sum_wide;
    logic [7:0]       cnt_inc;
    logic             last_beat;

    // started holds in_ready low while reset is asserted and until the first
    // clock edge after release.
    assign in_ready  = started && (state != HOLD);
    assign accept    = in_valid && in_ready;

    // One extra bit on the adder exposes overflow of the ACC_W-bit total.
    assign beat_ext  = {{(ACC_W-8){1'b0}}, in_cout, in_sum};
    assign sum_wide  = {1'b0, acc} + beat_ext;
    assign cnt_inc   = cnt + 8'd1;
    assign last_beat = (cnt_inc == COUNT_L);

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sat_next   = sat;

        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (sum_wide[ACC_W]) begin
                        acc_next = '1;
                        sat_next = 1'b1;
                    end else begin
                        acc_next = sum_wide[ACC_W-1:0];
                    end
                    cnt_next = cnt_inc;
                    // A beat arriving with flush still belongs to the frame.
                    state_next = (last_beat || flush) ? HOLD : ACCUM;
                end else if (flush && (state == ACCUM)) begin
                    // Flush in IDLE without a beat is ignored: no empty frames.
                    state_next = HOLD;
                end
            end

            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
                acc_next   = '0;
                cnt_next   = '0;
                sat_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
            started <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state   <= state_next;
            acc     <= acc_next;
            cnt     <= cnt_next;
            sat     <= sat_next;
            started <= 1'b1;
        end
    end

    // Outputs come straight from registers; they track the running total
    // and are only meaningful while out_valid is high.
    assign out_valid = (state == HOLD);
    assign out_acc   = acc;
    assign out_cnt   = cnt;
    assign out_sat   = sat;

endmodule

// File: tb/tb_sum_accumulator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sum_accumulator
//
// Main instance (COUNT=4, ACC_W=10) is driven with directed and random beats;
// a reference model closes frames from the accepted beat list and pushes the
// expected result into a scoreboard popped by an independent output monitor.
// A second instance (COUNT=200, ACC_W=16) covers long saturating frames.
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

    localparam int COUNT   = 4;
    localparam int ACC_W   = 10;
    localparam int B_COUNT = 200;
    localparam int B_ACC_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [7:0]       in_sum    = 8'd0;
    logic             in_cout   = 1'b0;
    logic             flush     = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_acc;
    logic [7:0]       out_cnt;
    logic             out_sat;

    logic               b_in_valid  = 1'b0;
    logic               b_in_ready;
    logic [7:0]         b_in_sum    = 8'd0;
    logic               b_in_cout   = 1'b0;
    logic               b_flush     = 1'b0;
    logic               b_out_valid;
    logic               b_out_ready = 1'b0;
    logic [B_ACC_W-1:0] b_out_acc;
    logic [7:0]         b_out_cnt;
    logic               b_out_sat;

    sum_accumulator #(.COUNT(COUNT), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_cnt(out_cnt), .out_sat(out_sat)
    );

    sum_accumulator #(.COUNT(B_COUNT), .ACC_W(B_ACC_W)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sum(b_in_sum), .in_cout(b_in_cout), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_acc(b_out_acc), .out_cnt(b_out_cnt), .out_sat(b_out_sat)
    );

    typedef struct {
        longint acc;
        longint cnt;
        longint sat;
        longint close_cyc;
    } frame_t;

    frame_t sb[$];
    int     beats[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    logic   prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: compares whatever the DUT presents against the oldest
    // expected frame and retires it on the handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual acc=%0h cnt=%0d expected no frame", out_acc, out_cnt);
                end else begin
                    check("out_acc", out_acc, sb[0].acc);
                    check("out_cnt", out_cnt, sb[0].cnt);
                    check("out_sat", out_sat, sb[0].sat);
                    if (!prev_valid) check("latency", cyc, sb[0].close_cyc + 1);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_valid <= out_valid;
        end
    end

    // Reference model: a frame is the list of accepted beats; its result is
    // the plain sum clamped to the ACC_W range.
    task automatic close_frame();
        frame_t f;
        longint total = 0;
        longint max_v = (longint'(1) << ACC_W) - 1;
        foreach (beats[i]) total += beats[i];
        f.acc       = (total > max_v) ? max_v : total;
        f.sat       = (total > max_v) ? 1 : 0;
        f.cnt       = beats.size();
        f.close_cyc = cyc;
        sb.push_back(f);
        beats.delete();
    endtask

    // One clock cycle of stimulus; entered and left at posedge + 1.
    task automatic step(input bit v, input int beat, input bit fl, input bit ordy);
        in_valid  = v;
        in_cout   = beat[8];
        in_sum    = beat[7:0];
        flush     = fl;
        out_ready = ordy;
        check("in_ready", in_ready, (sb.size() == 0) ? 1 : 0);
        @(negedge clk);
        if (in_ready) begin
            if (v) beats.push_back(beat);
            if (beats.size() > 0 && (fl || beats.size() == COUNT)) close_frame();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_acc",   out_acc,   0);
        check("rst_out_cnt",   out_cnt,   0);
        check("rst_out_sat",   out_sat,   0);
        check("rst_in_ready",  in_ready,  0);
        beats.delete();
        sb.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1 check("in_ready_after_release", in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("init_out_valid", out_valid, 0);
        check("init_out_acc",   out_acc,   0);
        check("init_in_ready",  in_ready,  0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("init_in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1 check("init_in_ready_after_edge", in_ready, 1);

        // Four-beat frame with carries.
        step(1'b1, 'h005, 1'b0, 1'b1);
        step(1'b1, 'h100, 1'b0, 1'b1);
        step(1'b1, 'h0FF, 1'b0, 1'b1);
        step(1'b1, 'h100, 1'b0, 1'b1);
        check("kat_4beat_acc", out_acc, 'h304);
        check("kat_4beat_cnt", out_cnt, 4);
        idle(2);

        // Flush without a beat after two beats; next frame starts from zero.
        step(1'b1, 'h1FF, 1'b0, 1'b1);
        step(1'b1, 'h100, 1'b0, 1'b1);
        step(1'b0, 0,     1'b1, 1'b1);
        check("kat_flush_acc", out_acc, 'h2FF);
        check("kat_flush_cnt", out_cnt, 2);
        idle(2);

        // Beat and flush on the same edge.
        step(1'b1, 'h010, 1'b0, 1'b1);
        step(1'b1, 'h020, 1'b1, 1'b1);
        check("kat_beatflush_acc", out_acc, 'h030);
        check("kat_beatflush_cnt", out_cnt, 2);
        idle(2);

        // Flush in IDLE: ignored alone, one-beat frame with a beat.
        step(1'b0, 0,     1'b1, 1'b1);
        step(1'b0, 0,     1'b1, 1'b1);
        step(1'b1, 'h007, 1'b1, 1'b1);
        idle(2);

        // Saturating frame.
        for (int i = 0; i < 4; i++) step(1'b1, 'h1FF, 1'b0, 1'b1);
        check("kat_sat", out_sat, 1);
        idle(2);

        // Back-pressure in HOLD with in_valid high and stray flushes.
        for (int i = 0; i < 4; i++) step(1'b1, 'h011 + i, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 'h040, (i % 3) == 0, 1'b0);
        step(1'b1, 'h040, 1'b0, 1'b1);
        step(1'b1, 'h041, 1'b0, 1'b1);
        step(1'b1, 'h042, 1'b1, 1'b1);
        idle(2);

        // Reset mid-frame, then a clean frame of ones.
        step(1'b1, 'h0AA, 1'b0, 1'b1);
        step(1'b1, 'h0BB, 1'b0, 1'b1);
        pulse_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 'h001, 1'b0, 1'b1);
        check("kat_after_reset_acc", out_acc, 'h004);
        check("kat_after_reset_cnt", out_cnt, 4);
        idle(2);

        // Reset while holding a result: nothing emitted afterwards.
        for (int i = 0; i < 4; i++) step(1'b1, 'h033, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        pulse_reset();
        idle(3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int b;
            b = ($urandom_range(0, 3) == 0) ? 'h1FF : int'($urandom_range(0, 511));
            step($urandom_range(0, 3) != 0, b, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0);
        end

        // Drain outstanding results.
        for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
        if (beats.size() > 0) begin
            step(1'b0, 0, 1'b1, 1'b1);
            for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
        end
        check("scoreboard_drained", sb.size(), 0);

        // Long saturating frame on the COUNT=200 instance.
        b_in_valid  = 1'b1;
        b_in_sum    = 8'hFF;
        b_in_cout   = 1'b1;
        b_out_ready = 1'b1;
        for (int i = 1; i <= B_COUNT; i++) begin
            @(posedge clk);
            #1;
            if (i == 128) begin
                check("b_run_acc_128", b_out_acc, 'hFF80);
                check("b_run_sat_128", b_out_sat, 0);
            end
            if (i == 129) begin
                check("b_run_acc_129", b_out_acc, 'hFFFF);
                check("b_run_sat_129", b_out_sat, 1);
            end
            if (i == B_COUNT) b_in_valid = 1'b0;
        end
        check("b_out_valid", b_out_valid, 1);
        check("b_out_acc",   b_out_acc,   'hFFFF);
        check("b_out_cnt",   b_out_cnt,   200);
        check("b_out_sat",   b_out_sat,   1);
        @(posedge clk);
        #1;
        check("b_released", b_out_valid, 0);
        check("b_cleared_acc", b_out_acc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter COUNT, default 4, meaning the number of accepted beats per frame (legal range 1..255).
REQ-002 The block SHALL have parameter ACC_W, default 16, meaning the width of the accumulator and result (legal range 9..32).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: in_sum and in_cout carry a valid beat.
REQ-006 Port in_ready, output, 1 bit: block can accept a beat this cycle.
REQ-007 Port in_sum, input, 8 bits: sum output of the upstream 8-bit carry-propagate adder.
REQ-008 Port in_cout, input, 1 bit: carry-out of the upstream adder.
REQ-009 Port flush, input, 1 bit: close the current frame early with whatever beats it has accepted.
REQ-010 Port out_valid, output, 1 bit: result is valid.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 Port out_acc, output, ACC_W bits: frame total.
REQ-013 Port out_cnt, output, 8 bits: number of beats in the frame.
REQ-014 Port out_sat, output, 1 bit: the frame total saturated.

Function
REQ-015 A beat SHALL be accepted on a rising clk edge where in_valid and in_ready are both 1.
REQ-016 Each accepted beat SHALL add the 9-bit value {in_cout, in_sum}, zero-extended to ACC_W+1 bits, to the accumulator.
REQ-017 If an addition exceeds 2^ACC_W-1, the accumulator SHALL clamp to all-ones, set a sticky sat bit, and keep that sat bit for the rest of the frame.
REQ-018 The state machine SHALL have three states:
- IDLE: accumulator = 0, count = 0, in_ready = 1, out_valid = 0.
- ACCUM: in_ready = 1, out_valid = 0.
- HOLD: in_ready = 0, out_valid = 1.
REQ-019 IDLE SHALL move to ACCUM on an accepted beat.
REQ-020 ACCUM SHALL move to HOLD in the same edge that accepts beat number COUNT.
REQ-021 If COUNT = 1, IDLE SHALL move directly to HOLD on the first accepted beat.
REQ-022 Latency SHALL be one cycle: out_valid rises in the cycle after the final beat is accepted, with out_acc including that beat.
REQ-023 flush = 1 in ACCUM SHALL move to HOLD at that edge, with out_cnt equal to the beats accepted so far.
REQ-024 If a beat is accepted in the same edge as a flush in ACCUM, that beat SHALL be included in the frame.
REQ-025 flush = 1 in IDLE with no beat accepted SHALL be ignored; no empty frames are emitted.
REQ-026 flush = 1 in IDLE with a beat accepted SHALL emit a one-beat frame.
REQ-027 flush in HOLD SHALL be ignored.
REQ-028 In HOLD, out_acc, out_cnt and out_sat SHALL stay stable until out_valid && out_ready.
REQ-029 On out_valid && out_ready, the block SHALL clear the accumulator, count and sat bit and return to IDLE; in_ready = 1 in the next cycle (no same-cycle bypass).
REQ-030 out_acc, out_cnt and out_sat SHALL be driven from registers only, with no combinational path from inputs to outputs.
REQ-031 in_ready SHALL depend only on state; it SHALL NOT depend combinationally on out_ready.
REQ-032 out_acc, out_cnt and out_sat are don't-care while out_valid = 0, but SHALL reflect the running accumulator, count and sat bit.

Reset
REQ-033 rst_n = 0 SHALL immediately (asynchronously) force IDLE, accumulator = 0, count = 0, sat = 0, out_valid = 0, out_acc = 0, out_cnt = 0, out_sat = 0 and in_ready = 0.
REQ-034 in_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-035 Reset asserted mid-frame or in HOLD SHALL discard the partial frame or held result; nothing is emitted after release.

Verification
REQ-036 COUNT = 4, out_ready = 1, beats {cout,sum} = 0x005, 0x100, 0x0FF, 0x100 -> one cycle after the 4th beat: out_valid = 1, out_acc = 0x0304, out_cnt = 4, out_sat = 0.
REQ-037 COUNT = 4, beats 0x1FF and 0x100, then flush with no beat -> out_acc = 0x02FF, out_cnt = 2; the next frame starts from 0.
REQ-038 COUNT = 200, ACC_W = 16, 200 beats of 0x1FF -> out_acc = 0xFFFF, out_sat = 1, out_cnt = 200.
REQ-039 out_ready = 0 for 10 cycles while in HOLD, in_valid held at 1 -> in_ready = 0, outputs stable, no beat lost; frame accepted on the first cycle out_ready = 1.
REQ-040 rst_n pulsed low after 2 beats -> outputs 0 immediately; a following 4-beat frame of 0x001 -> out_acc = 0x0004, out_cnt = 4.
REQ-041 A beat and flush in the same edge in ACCUM after 1 prior beat (0x010, then 0x020 + flush) -> out_acc = 0x0030, out_cnt = 2.
